bka_serial_adder_ctrl: RTL and testbench
========================================

BKA_SERIAL_ADDER_CTRL -- requirements
Module: bka_serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width W = 4*NIBBLES bits (NIBBLES >= 2).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port valid_i, input, 1, operand request valid.
REQ-005 The block SHALL have port ready_o, output, 1, block can accept an operand request.
REQ-006 The block SHALL have ports A_i and B_i, input, W each, the addends.
REQ-007 The block SHALL have port c_i, input, 1, the carry-in.
REQ-008 The block SHALL have port valid_o, output, 1, result valid.
REQ-009 The block SHALL have port ready_i, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port S_o, output, W, the sum.
REQ-011 The block SHALL have port c_o, output, 1, the carry-out.
REQ-012 The block SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-013 The block SHALL instantiate exactly one brent_kung_adder_4bit and compute the W-bit sum one nibble per cycle, least-significant nibble first.
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 ready_o SHALL be high only in IDLE; the request handshake completes on a rising edge with valid_i and ready_o both high.
REQ-016 On request handshake, the block SHALL register A_i, B_i and c_i, clear the nibble counter to 0, load the carry register with c_i, and go IDLE->CALC.
REQ-017 In CALC, adder inputs SHALL be nibble[cnt] of the registered A and B plus the carry register; each edge SHALL write the adder sum into nibble[cnt] of the result register, load the adder c_o into the carry register, and increment cnt.
REQ-018 When the edge processes nibble NIBBLES-1, the FSM SHALL go CALC->DONE; the final carry becomes c_o.
REQ-019 Latency SHALL be exactly NIBBLES edges from the request handshake edge to valid_o high (4 for the default).
REQ-020 In DONE, valid_o SHALL be high, and S_o and c_o SHALL hold stable until the edge where ready_i is high; that edge SHALL go DONE->IDLE.
REQ-021 A new request SHALL NOT be accepted in the DONE->IDLE edge; the earliest next handshake is the following edge.
REQ-022 valid_i and operand inputs SHALL be ignored in CALC and DONE; registered operands SHALL NOT change there.
REQ-023 ready_i SHALL be ignored outside DONE.
REQ-024 S_o and c_o SHALL keep the last result in IDLE and CALC; only valid_o qualifies them.
REQ-025 Arithmetic SHALL be modulo 2^W; carry-out is bit W of A+B+c_i.

Reset
REQ-026 While rst_i is high, the block SHALL force state IDLE, cnt 0, carry register 0, operand and result registers 0, regardless of clk_i.
REQ-027 Reset values SHALL be valid_o=0, busy_o=0, S_o=0, c_o=0; ready_o SHALL be 0 while rst_i is high and 1 on the first cycle after release.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation; no valid_o pulse for it after release.

Verification
REQ-029 A=0xFFFF, B=0x0001, c_i=0 handshake -> valid_o high exactly 4 edges later, with S_o=0x0000 and c_o=1.
REQ-030 A=0x1234, B=0x4321, c_i=1 -> S_o=0x5556, c_o=0; busy_o high from handshake until ready_i accept.
REQ-031 Result 0x8000+0x8000+0 with ready_i low for 3 cycles in DONE -> valid_o, S_o=0x0000 and c_o=1 stay stable; IDLE follows the ready_i edge.
REQ-032 valid_i held high with new operands through CALC -> second request only after DONE->IDLE plus one edge; first result unaffected.
REQ-033 rst_i pulsed during the second CALC cycle of 0xAAAA+0x5555 -> outputs zero immediately; no valid_o afterwards; next request 0x0001+0x0001 -> 0x0002.
REQ-034 100 random A/B/c_i requests with random ready_i back-pressure -> every S_o/c_o matches the 17-bit golden A+B+c_i; each prints PASS/FAIL.

Source files
------------

// File: rtl/bka_serial_adder_ctrl.sv
// Nibble-serial W-bit adder: a single 4-bit Brent-Kung slice is reused once per cycle,
// least-significant nibble first, behind valid/ready handshakes on both sides.

module brent_kung_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic       g10, p10, g32, p32, g20, p20, g30, p30;
    logic [4:0] c;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = a_i[gi] & b_i[gi];
            assign p[gi] = a_i[gi] ^ b_i[gi];
        end
    endgenerate

    // Up-sweep pairs, then the down-sweep fills in the odd group (2:0).
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;
    assign g20 = g[2] | (p[2] & g10);
    assign p20 = p[2] & p10;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g10 | (p10 & c_i);
    assign c[3] = g20 | (p20 & c_i);
    assign c[4] = g30 | (p30 & c_i);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];
endmodule

module bka_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [4*NIBBLES-1:0] A_i,
    input  logic [4*NIBBLES-1:0] B_i,
    input  logic                 c_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [4*NIBBLES-1:0] S_o,
    output logic                 c_o,
    output logic                 busy_o
);
    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_work_reg;
    logic [W-1:0]     s_reg;
    logic             c_reg;

    logic [CNT_W+1:0] nib_base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_carry;
    logic             last_nib;
    logic [W-1:0]     sum_work_next;

    assign nib_base = {cnt_reg, 2'b00};
    assign nib_a    = a_reg[nib_base +: 4];
    assign nib_b    = b_reg[nib_base +: 4];
    assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

    brent_kung_adder_4bit u_bka (
        .a_i (nib_a),
        .b_i (nib_b),
        .c_i (carry_reg),
        .s_o (nib_sum),
        .c_o (nib_carry)
    );

    always_comb begin
        sum_work_next = sum_work_reg;
        sum_work_next[nib_base +: 4] = nib_sum;
    end

    // Partial sums build up in sum_work_reg; S_o/c_o only change on the final nibble
    // so the previous result stays visible while a new one is being computed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_work_reg <= '0;
            s_reg        <= '0;
            c_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg     <= A_i;
                        b_reg     <= B_i;
                        carry_reg <= c_i;
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    sum_work_reg <= sum_work_next;
                    carry_reg    <= nib_carry;
                    if (last_nib) begin
                        cnt_reg   <= '0;
                        s_reg     <= sum_work_next;
                        c_reg     <= nib_carry;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_reg == IDLE) & ~rst_i;
    assign valid_o = (state_reg == DONE);
    assign busy_o  = (state_reg != IDLE);
    assign S_o     = s_reg;
    assign c_o     = c_reg;
endmodule

// File: tb/tb_bka_serial_adder_ctrl.sv
// Directed and randomised checks of the nibble-serial adder controller.

module tb_bka_serial_adder_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] A_i;
    logic [15:0] B_i;
    logic        c_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] S_o;
    logic        c_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    bka_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .A_i     (A_i),
        .B_i     (B_i),
        .c_i     (c_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .S_o     (S_o),
        .c_o     (c_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and return just after its handshake edge.
    task automatic req(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        A_i = a;
        B_i = b;
        c_i = c;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 20) begin
            tick;
            n++;
        end
        chk("req_ready", {31'b0, ready_o}, 32'd1);
        tick;
        valid_i = 1'b0;
        chk("req_busy", {31'b0, busy_o}, 32'd1);
    endtask

    // Count edges until valid_o; optionally toggle ready_i randomly while waiting.
    task automatic wait_valid(input bit rand_rdy, output int lat);
        lat = 0;
        while (!valid_o && lat < 20) begin
            if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
            tick;
            lat++;
        end
        ready_i = 1'b0;
        chk("valid_timeout", {31'b0, valid_o}, 32'd1);
    endtask

    task automatic accept;
        ready_i = 1'b1;
        tick;
        ready_i = 1'b0;
    endtask

    initial begin
        int lat;
        logic [16:0] gold;
        int err_before;
        logic [15:0] ra, rb;
        logic rc;
        int bp;

        rst_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        A_i = '0;
        B_i = '0;
        c_i = 1'b0;

        // Reset state
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd0);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_sum", {15'b0, c_o, S_o}, 32'd0);
        repeat (3) tick;
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, ready_o}, 32'd1);

        // 0xFFFF + 0x0001 + 0: exact latency, wrap with carry-out
        req(16'hFFFF, 16'h0001, 1'b0);
        lat = 0;
        repeat (3) begin
            tick;
            lat++;
            chk("lat_early_valid", {31'b0, valid_o}, 32'd0);
        end
        tick;
        chk("lat_valid_at_4", {31'b0, valid_o}, 32'd1);
        chk("ffff_sum", {15'b0, c_o, S_o}, 32'h1_0000);
        $display("txn ffff+0001+0 S=0x%04h c=%0d", S_o, c_o);
        accept;
        chk("ffff_idle_valid", {31'b0, valid_o}, 32'd0);
        chk("ffff_idle_busy", {31'b0, busy_o}, 32'd0);
        chk("ffff_idle_ready", {31'b0, ready_o}, 32'd1);

        // 0x1234 + 0x4321 + 1: busy throughout, previous result held during CALC
        req(16'h1234, 16'h4321, 1'b1);
        repeat (3) begin
            tick;
            chk("1234_busy", {31'b0, busy_o}, 32'd1);
            chk("1234_hold_prev", {15'b0, c_o, S_o}, 32'h1_0000);
        end
        tick;
        chk("1234_valid", {31'b0, valid_o}, 32'd1);
        chk("1234_sum", {15'b0, c_o, S_o}, 32'h0_5556);
        $display("txn 1234+4321+1 S=0x%04h c=%0d", S_o, c_o);
        chk("1234_busy_done", {31'b0, busy_o}, 32'd1);
        accept;
        chk("1234_busy_after", {31'b0, busy_o}, 32'd0);

        // 0x8000 + 0x8000 + 0 with three cycles of back-pressure
        req(16'h8000, 16'h8000, 1'b0);
        wait_valid(1'b0, lat);
        chk("8000_lat", lat, 32'd4);
        repeat (3) begin
            tick;
            chk("8000_hold_valid", {31'b0, valid_o}, 32'd1);
            chk("8000_hold_sum", {15'b0, c_o, S_o}, 32'h1_0000);
        end
        $display("txn 8000+8000+0 S=0x%04h c=%0d", S_o, c_o);
        accept;
        chk("8000_idle", {31'b0, ready_o}, 32'd1);

        // valid_i held high with changing operands through CALC
        A_i = 16'h1111;
        B_i = 16'h2222;
        c_i = 1'b0;
        valid_i = 1'b1;
        tick;
        chk("hold_first_busy", {31'b0, busy_o}, 32'd1);
        A_i = 16'h0F0F;
        B_i = 16'h0101;
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick;
            lat++;
        end
        chk("hold_first_lat", lat, 32'd4);
        chk("hold_first_sum", {15'b0, c_o, S_o}, 32'h0_3333);
        $display("txn 1111+2222+0 S=0x%04h c=%0d", S_o, c_o);
        ready_i = 1'b1;
        tick;
        ready_i = 1'b0;
        chk("hold_no_accept_on_exit", {31'b0, busy_o}, 32'd0);
        chk("hold_ready_after_exit", {31'b0, ready_o}, 32'd1);
        tick;
        valid_i = 1'b0;
        chk("hold_second_accepted", {31'b0, busy_o}, 32'd1);
        wait_valid(1'b0, lat);
        chk("hold_second_lat", lat, 32'd4);
        chk("hold_second_sum", {15'b0, c_o, S_o}, 32'h0_1010);
        $display("txn 0f0f+0101+0 S=0x%04h c=%0d", S_o, c_o);
        accept;

        // Reset in the second CALC cycle aborts the operation
        req(16'hAAAA, 16'h5555, 1'b0);
        tick;
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_sum_zero", {15'b0, c_o, S_o}, 32'd0);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_ready", {31'b0, ready_o}, 32'd0);
        chk("abort_valid", {31'b0, valid_o}, 32'd0);
        tick;
        rst_i = 1'b0;
        repeat (8) begin
            tick;
            chk("abort_no_valid", {31'b0, valid_o}, 32'd0);
        end
        req(16'h0001, 16'h0001, 1'b0);
        wait_valid(1'b0, lat);
        chk("abort_next_sum", {15'b0, c_o, S_o}, 32'h0_0002);
        $display("txn 0001+0001+0 S=0x%04h c=%0d", S_o, c_o);
        accept;

        // Random requests with back-pressure on the result side
        for (int i = 0; i < 100; i++) begin
            err_before = errors;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            gold = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            req(ra, rb, rc);
            wait_valid(1'b1, lat);
            chk("rand_lat", lat, 32'd4);
            chk("rand_sum", {15'b0, c_o, S_o}, {15'b0, gold});
            bp = $urandom_range(0, 3);
            repeat (bp) begin
                tick;
                chk("rand_hold", {14'b0, valid_o, c_o, S_o}, {14'b0, 1'b1, gold});
            end
            accept;
            if (errors == err_before)
                $display("txn %0d A=0x%04h B=0x%04h c=%0d S=0x%04h c_o=%0d PASS", i, ra, rb, rc, S_o, c_o);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
